// File: rtl/smpc_pad_reader.sv
// SMPC-side initiator for the Saturn TH/TR/TL peripheral handshake on one port.
// Reads the class nibble, ID byte and payload nibbles, and emits assembled bytes.
module smpc_pad_reader #(
    parameter int SETTLE_CE  = 2,
    parameter int TIMEOUT_CE = 255,
    parameter int MAX_BYTES  = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic       START,
    output logic [6:0] PDRO,
    output logic [6:0] DDR,
    input  logic [6:0] PDRI,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] STATUS,
    output logic [3:0] CLASS,
    output logic [7:0] ID,
    output logic [3:0] LEN,
    output logic       DATA_WE,
    output logic [2:0] DATA_ADDR,
    output logic [7:0] DATA
);
    localparam int SW = (SETTLE_CE > 1) ? $clog2(SETTLE_CE) : 1;
    localparam int TW = $clog2(TIMEOUT_CE + 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CE - 1);
    localparam logic [3:0]    MAX_LEN      = 4'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_SETTLE  = 3'd2,
        S_POLL    = 3'd3,
        S_CAPTURE = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [4:0]      r_k, w_k_nxt;
    logic [SW-1:0]   r_set, w_set_nxt;
    logic [TW-1:0]   r_tmo, w_tmo_nxt;
    logic            r_th, w_th_nxt;
    logic            r_tr, w_tr_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic [1:0]      r_status, w_status_nxt;
    logic [3:0]      r_class, w_class_nxt;
    logic [7:0]      r_id, w_id_nxt;
    logic [3:0]      r_len, w_len_nxt;
    logic            r_we, w_we_nxt;
    logic [2:0]      r_addr, w_addr_nxt;
    logic [7:0]      r_data, w_data_nxt;
    logic [3:0]      r_hi, w_hi_nxt;
    logic [3:0]      w_nib;
    logic [4:0]      w_off;
    logic            w_fin;
    logic            w_unused;

    assign w_nib    = PDRI[3:0];
    assign w_off    = r_k - 5'd4;
    assign w_unused = ^{PDRI[6:5], w_off[4], w_off[0]};

    // Next-state and next-register values; everything commits on a CE tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_k_nxt      = r_k;
        w_set_nxt    = r_set;
        w_tmo_nxt    = r_tmo;
        w_th_nxt     = r_th;
        w_tr_nxt     = r_tr;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_status_nxt = r_status;
        w_class_nxt  = r_class;
        w_id_nxt     = r_id;
        w_len_nxt    = r_len;
        w_we_nxt     = 1'b0;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_hi_nxt     = r_hi;
        w_fin        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_th_nxt = 1'b1;
                w_tr_nxt = 1'b1;
                if (START) begin
                    w_state_nxt  = S_REQ;
                    w_busy_nxt   = 1'b1;
                    w_k_nxt      = 5'd0;
                    w_status_nxt = 2'd0;
                    w_class_nxt  = 4'd0;
                    w_id_nxt     = 8'd0;
                    w_len_nxt    = 4'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                w_th_nxt    = 1'b0;
                w_tr_nxt    = ~r_k[0];
                w_set_nxt   = '0;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_set == SETTLE_LAST) begin
                    w_state_nxt = S_POLL;
                    w_tmo_nxt   = '0;
                end else begin
                    w_set_nxt = r_set + 1'b1;
                end
            end
            S_POLL: begin
                if (PDRI[4] == r_tr) begin
                    w_state_nxt = S_CAPTURE;
                end else if (r_tmo == TIMEOUT_LAST) begin
                    w_status_nxt = 2'd1;
                    w_fin        = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            S_CAPTURE: begin
                if (r_k == 5'd0) begin
                    w_class_nxt = w_nib;
                    if ((w_nib != 4'h1) && (w_nib != 4'hB)) begin
                        w_status_nxt = 2'd2;
                        w_fin        = 1'b1;
                    end else begin
                        w_fin = 1'b0;
                    end
                end else if (r_k == 5'd1) begin
                    w_id_nxt[7:4] = w_nib;
                end else if (r_k == 5'd2) begin
                    w_id_nxt[3:0] = w_nib;
                    // The mouse class always carries three bytes regardless of its ID.
                    if (r_class == 4'h1) begin
                        w_len_nxt = (w_nib > MAX_LEN) ? MAX_LEN : w_nib;
                    end else begin
                        w_len_nxt = 4'd3;
                    end
                end else if (r_k[0]) begin
                    w_hi_nxt = w_nib;
                end else begin
                    w_data_nxt = {r_hi, w_nib};
                    w_addr_nxt = w_off[3:1];
                    w_we_nxt   = 1'b1;
                end
                if (r_k == (5'd2 + {w_len_nxt, 1'b0})) begin
                    w_fin = 1'b1;
                end else begin
                    w_k_nxt = (w_fin) ? r_k : (r_k + 5'd1);
                end
                if (!w_fin) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_FINISH: begin
                if (r_set == SETTLE_LAST) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_set_nxt = r_set + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_th_nxt    = 1'b1;
                w_tr_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
        // Releasing TH/TR to 11 is what returns the device to its first nibble.
        if (w_fin) begin
            w_state_nxt = S_FINISH;
            w_set_nxt   = '0;
            w_th_nxt    = 1'b1;
            w_tr_nxt    = 1'b1;
        end else begin
            w_set_nxt = w_set_nxt;
        end
    end

    // State and datapath registers; reset is synchronous and ignores CE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_k      <= 5'd0;
            r_set    <= '0;
            r_tmo    <= '0;
            r_th     <= 1'b1;
            r_tr     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_status <= 2'd0;
            r_class  <= 4'd0;
            r_id     <= 8'd0;
            r_len    <= 4'd0;
            r_we     <= 1'b0;
            r_addr   <= 3'd0;
            r_data   <= 8'd0;
            r_hi     <= 4'd0;
        end else if (CE) begin
            r_state  <= w_state_nxt;
            r_k      <= w_k_nxt;
            r_set    <= w_set_nxt;
            r_tmo    <= w_tmo_nxt;
            r_th     <= w_th_nxt;
            r_tr     <= w_tr_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_status <= w_status_nxt;
            r_class  <= w_class_nxt;
            r_id     <= w_id_nxt;
            r_len    <= w_len_nxt;
            r_we     <= w_we_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_hi     <= w_hi_nxt;
        end
    end

    assign PDRO      = {r_th, r_tr, 5'h1F};
    assign DDR       = 7'h60;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign STATUS    = r_status;
    assign CLASS     = r_class;
    assign ID        = r_id;
    assign LEN       = r_len;
    assign DATA_WE   = r_we;
    assign DATA_ADDR = r_addr;
    assign DATA      = r_data;
endmodule

// File: tb/tb_smpc_pad_reader.sv
// Bench for smpc_pad_reader: a behavioural Saturn peripheral replays a nibble stream
// and each read is checked against the class/ID/length rules of the protocol.
module tb_smpc_pad_reader;
    logic       CLK, RST, CE, START;
    logic [6:0] PDRO, DDR, PDRI;
    logic       BUSY, DONE, DATA_WE;
    logic [1:0] STATUS;
    logic [3:0] CLASS, LEN;
    logic [7:0] ID, DATA;
    logic [2:0] DATA_ADDR;

    int errors = 0;
    int checks = 0;
    int ce_div = 1;
    int ce_cnt = 0;

    logic [3:0] nib_q[$];
    logic [7:0] pay[$];
    bit         tl_tied = 1'b0;
    logic       th_s = 1'b1, tr_s = 1'b1;
    int         dev_idx = 0;
    logic       dev_prev_th = 1'b1, dev_prev_tr = 1'b1;

    logic [2:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int         done_cnt = 0;
    logic       prev_we = 1'b0, prev_done = 1'b0;
    int         done0 = 0;
    int         elapsed = 0;

    smpc_pad_reader dut (
        .CLK(CLK), .RST(RST), .CE(CE), .START(START),
        .PDRO(PDRO), .DDR(DDR), .PDRI(PDRI),
        .BUSY(BUSY), .DONE(DONE), .STATUS(STATUS), .CLASS(CLASS),
        .ID(ID), .LEN(LEN), .DATA_WE(DATA_WE), .DATA_ADDR(DATA_ADDR), .DATA(DATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Clock-enable generator and output monitor, both on the inactive edge.
    initial begin
        CE = 1'b0;
        forever begin
            @(negedge CLK);
            th_s = PDRO[6];
            tr_s = PDRO[5];
            if (DATA_WE && !prev_we) begin
                wr_addr.push_back(DATA_ADDR);
                wr_data.push_back(DATA);
            end
            if (DONE && !prev_done) done_cnt++;
            prev_we   = DATA_WE;
            prev_done = DONE;
            ce_cnt++;
            CE = ((ce_cnt % ce_div) == 0);
        end
    end

    // Peripheral: TH high rewinds it; each new TR level (or TH falling) serves the next nibble.
    initial begin
        logic [3:0] nib;
        PDRI = 7'h7F;
        forever begin
            @(posedge CLK);
            #1;
            if (th_s) begin
                dev_idx     = 0;
                dev_prev_th = 1'b1;
                PDRI        = 7'h7F;
            end else if (dev_prev_th || (tr_s != dev_prev_tr)) begin
                nib  = (dev_idx < nib_q.size()) ? nib_q[dev_idx] : 4'h0;
                PDRI = {2'b11, (tl_tied ? 1'b1 : tr_s), nib};
                dev_idx++;
                dev_prev_th = 1'b0;
                dev_prev_tr = tr_s;
            end
        end
    end

    task automatic load_device(input logic [3:0] cls, input logic [7:0] id);
        nib_q.delete();
        nib_q.push_back(cls);
        nib_q.push_back(id[7:4]);
        nib_q.push_back(id[3:0]);
        foreach (pay[i]) begin
            nib_q.push_back(pay[i][7:4]);
            nib_q.push_back(pay[i][3:0]);
        end
    endtask

    task automatic start_read(input string tag);
        int n;
        wr_addr.delete();
        wr_data.delete();
        done0 = done_cnt;
        @(negedge CLK);
        START = 1'b1;
        n = 0;
        while (!BUSY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        START   = 1'b0;
        elapsed = 0;
        checks++;
        if (!BUSY) begin
            errors++;
            $display("FAIL %s start: BUSY=%0b want 1", tag, BUSY);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == done0 && n < 20000) begin
            @(negedge CLK);
            n++;
            elapsed++;
        end
        checks++;
        if (done_cnt == done0) begin
            errors++;
            $display("FAIL %s done_wait: no DONE within %0d cycles", tag, n);
        end
        repeat (20) @(negedge CLK);
    endtask

    task automatic verify_read(input string tag, input logic [1:0] es, input logic [3:0] ec,
                               input logic [7:0] eid, input int elen);
        checks++;
        if (STATUS !== es) begin errors++; $display("FAIL %s status: got %0d want %0d", tag, STATUS, es); end
        checks++;
        if (CLASS !== ec) begin errors++; $display("FAIL %s class: got %h want %h", tag, CLASS, ec); end
        checks++;
        if (ID !== eid) begin errors++; $display("FAIL %s id: got %h want %h", tag, ID, eid); end
        checks++;
        if (LEN !== 4'(elen)) begin errors++; $display("FAIL %s len: got %0d want %0d", tag, LEN, elen); end
        checks++;
        if (wr_data.size() != elen) begin
            errors++;
            $display("FAIL %s write_count: got %0d want %0d", tag, wr_data.size(), elen);
        end
        for (int i = 0; i < wr_data.size() && i < elen; i++) begin
            checks++;
            if (wr_addr[i] !== 3'(i) || wr_data[i] !== pay[i]) begin
                errors++;
                $display("FAIL %s byte%0d: got addr %0d data %h want addr %0d data %h",
                         tag, i, wr_addr[i], wr_data[i], i, pay[i]);
            end
        end
        checks++;
        if (done_cnt - done0 != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt - done0);
        end
        checks++;
        if (PDRO !== 7'h7F || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_lines: got PDRO=%h BUSY=%0b want 7f/0", tag, PDRO, BUSY);
        end
    endtask

    // Full read of a device from protocol rules: classes 1 and B are the only ones understood.
    task automatic read_device(input string tag, input logic [3:0] cls, input logic [7:0] id);
        logic [1:0] es;
        int         elen;
        load_device(cls, id);
        es = (cls == 4'h1 || cls == 4'hB) ? 2'd0 : 2'd2;
        if (cls == 4'h1)      elen = (int'(id[3:0]) > 8) ? 8 : int'(id[3:0]);
        else if (cls == 4'hB) elen = 3;
        else                  elen = 0;
        start_read(tag);
        wait_done(tag);
        verify_read(tag, es, cls, (es == 2'd0) ? id : 8'h00, elen);
    endtask

    task automatic test_reset();
        RST   = 1'b1;
        START = 1'b1;
        repeat (4) @(negedge CLK);
        checks++;
        if (PDRO !== 7'h7F || DDR !== 7'h60) begin
            errors++; $display("FAIL reset_port: got PDRO=%h DDR=%h want 7f/60", PDRO, DDR);
        end
        checks++;
        if ({BUSY, DONE, DATA_WE} !== 3'b000 || STATUS !== 2'd0 || CLASS !== 4'd0) begin
            errors++; $display("FAIL reset_flags: got busy/done/we=%b status=%0d class=%h", {BUSY, DONE, DATA_WE}, STATUS, CLASS);
        end
        checks++;
        if (ID !== 8'd0 || LEN !== 4'd0 || DATA_ADDR !== 3'd0 || DATA !== 8'd0) begin
            errors++; $display("FAIL reset_data: got id=%h len=%0d addr=%0d data=%h", ID, LEN, DATA_ADDR, DATA);
        end
        START = 1'b0;
        RST   = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_mission_stick();
        ce_div = 1;
        pay = '{8'hFF, 8'hF0, 8'h00, 8'hFF, 8'h00};
        read_device("stick", 4'h1, 8'h15);
    endtask

    task automatic test_mouse();
        pay = '{8'h01, 8'h12, 8'hFE};
        read_device("mouse", 4'hB, 8'hFF);
    endtask

    task automatic test_timeout();
        pay = '{8'h12, 8'h34};
        tl_tied = 1'b1;
        load_device(4'h1, 8'h12);
        start_read("timeout");
        wait_done("timeout");
        verify_read("timeout", 2'd1, 4'h1, 8'h00, 0);
        checks++;
        if (elapsed < 258 || elapsed > 295) begin
            errors++; $display("FAIL timeout_duration: got %0d cycles want about 265", elapsed);
        end
        tl_tied = 1'b0;
    endtask

    task automatic test_bad_class();
        pay = '{8'h55};
        read_device("bad_class", 4'hF, 8'h11);
    endtask

    task automatic test_clamp();
        pay.delete();
        for (int i = 0; i < 16; i++) pay.push_back(8'($urandom));
        read_device("clamp", 4'h1, 8'h1F);
    endtask

    task automatic test_reset_mid_read();
        int n;
        int d;
        pay = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        load_device(4'h1, 8'h16);
        start_read("rst_mid");
        n = 0;
        while (wr_data.size() < 2 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        repeat (3) @(negedge CLK);
        d   = done_cnt;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (PDRO !== 7'h7F || BUSY !== 1'b0 || DONE !== 1'b0 || STATUS !== 2'd0) begin
            errors++; $display("FAIL rst_mid_clear: got PDRO=%h BUSY=%0b DONE=%0b STATUS=%0d", PDRO, BUSY, DONE, STATUS);
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (30) @(negedge CLK);
        checks++;
        if (done_cnt != d || wr_data.size() != 2) begin
            errors++; $display("FAIL rst_mid_quiet: got dones=%0d writes=%0d want %0d/2", done_cnt - d, wr_data.size(), 0);
        end
        ce_div = 4;
        pay = '{8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h0F, 8'hF0};
        read_device("rst_after_ce4", 4'h1, 8'h16);
        ce_div = 1;
    endtask

    task automatic test_random();
        logic [3:0] cls;
        logic [7:0] id;
        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 3))
                0, 1: begin cls = 4'h1; id = {4'h1, 4'($urandom)}; end
                2:    begin cls = 4'hB; id = 8'hFF; end
                default: begin cls = 4'($urandom); id = 8'($urandom); end
            endcase
            ce_div = (r % 3 == 0) ? 1 : ((r % 3 == 1) ? 2 : 4);
            pay.delete();
            for (int i = 0; i < 16; i++) pay.push_back(8'($urandom));
            read_device($sformatf("random%0d", r), cls, id);
        end
        ce_div = 1;
    endtask

    task automatic test_back_to_back();
        int n;
        pay = '{8'h9A, 8'h7E};
        load_device(4'h1, 8'h12);
        wr_addr.delete();
        wr_data.delete();
        done0 = done_cnt;
        @(negedge CLK);
        START = 1'b1;
        n = 0;
        while (done_cnt == done0 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (wr_data.size() != 2 || wr_data[0] !== 8'h9A || wr_data[1] !== 8'h7E || STATUS !== 2'd0) begin
            errors++; $display("FAIL b2b_first: got writes=%0d status=%0d want 2/0", wr_data.size(), STATUS);
        end
        wr_addr.delete();
        wr_data.delete();
        done0 = done_cnt;
        n = 0;
        while (!BUSY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        START = 1'b0;
        checks++;
        if (!BUSY) begin
            errors++; $display("FAIL b2b_restart: got BUSY=%0b want 1", BUSY);
        end
        wait_done("b2b_second");
        verify_read("b2b_second", 2'd0, 4'h1, 8'h12, 2);
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        test_reset();
        test_mission_stick();
        test_mouse();
        test_timeout();
        test_bad_class();
        test_clamp();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
